// File: rtl/bank_switch_pkg.sv
// Shared packet, control and sizing definitions for the node mesh and bank crossbar.
// Pure declarations: no latency, no flow control.
package bank_switch_pkg;

  localparam int NODES_PER_BANK = 4;
  localparam int MESH_DIMENSION = 4;
  localparam int COORD_W        = $clog2(MESH_DIMENSION);
  // One spare bit so out-of-range node indices are representable and can be dropped.
  localparam int Z_W            = $clog2(NODES_PER_BANK) + 1;
  localparam int DATA_W         = 16;

  typedef enum logic [1:0] {
    CTRL_CHILDREN,
    CTRL_PARENTS,
    CTRL_START,
    CTRL_SUM
  } ctrl_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [Z_W-1:0]     z;
  } addr_t;

  typedef struct packed {
    ctrl_e             ctrl;
    addr_t             addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  function automatic logic addr_in_bank(input addr_t a, input int bx, input int by);
    return (a.x == COORD_W'(bx)) && (a.y == COORD_W'(by));
  endfunction

endpackage

// File: rtl/bank_switch_if.sv
// Mesh-side and node-side valid/ready bundle of one bank crossbar.
// slave = the crossbar itself, master = the router/node environment.
interface bank_switch_if
  import bank_switch_pkg::*;
#(
  parameter int NUM_NODES = NODES_PER_BANK
);

  logic                           mesh_valid_in;
  logic                           mesh_ready_in;
  pkt_t                           mesh_in_pkt;
  logic [NUM_NODES-1:0]           node_valid_out;
  logic [NUM_NODES-1:0]           node_ready_out;
  pkt_t                           node_out_pkt;
  logic [NUM_NODES-1:0]           node_valid_in;
  logic [NUM_NODES-1:0]           node_ready_in;
  pkt_t [NUM_NODES-1:0]           node_in_pkt;
  logic                           mesh_valid_out;
  logic                           mesh_ready_out;
  pkt_t                           mesh_out_pkt;

  modport slave (
    input  mesh_valid_in, mesh_in_pkt, node_ready_out,
    input  node_valid_in, node_in_pkt, mesh_ready_out,
    output mesh_ready_in, node_valid_out, node_out_pkt,
    output node_ready_in, mesh_valid_out, mesh_out_pkt
  );

  modport master (
    output mesh_valid_in, mesh_in_pkt, node_ready_out,
    output node_valid_in, node_in_pkt, mesh_ready_out,
    input  mesh_ready_in, node_valid_out, node_out_pkt,
    input  node_ready_in, mesh_valid_out, mesh_out_pkt
  );

endinterface

// File: rtl/bank_switch_rr_arbiter.sv
// Round-robin picker: candidate is first requester at/after the pointer; grant is
// combinational and one-hot when en is high, pointer moves past the winner only on grant.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic             cand_vld,
  output logic [IDX_W-1:0] cand_idx,
  output logic [N-1:0]     gnt
);

  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    cand_vld = 1'b0;
    cand_idx = '0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (sum >= SUM_W'(N)) sum = sum - SUM_W'(N);
      idx = sum[IDX_W-1:0];
      if (!cand_vld && req[idx]) begin
        cand_vld = 1'b1;
        cand_idx = idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = cand_vld && en && (cand_idx == IDX_W'(i));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (cand_vld && en) begin
      rr_ptr_d = (cand_idx == IDX_W'(N - 1)) ? '0 : cand_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/bank_switch.sv
// Bank crossbar: one-entry ingress slot (mesh->node by addr.z) and egress slot (RR nodes->mesh),
// 1-cycle latency each, full throughput, ready drops only when a slot is full and not popping.
// BANK_LOCAL_BYPASS_EN: egress packets addressed to this bank loop straight into the ingress slot.
module bank_switch
  import bank_switch_pkg::*;
#(
  parameter int BANK_X    = 0,
  parameter int BANK_Y    = 0,
  parameter int NUM_NODES = NODES_PER_BANK
) (
  input  logic                 clk,
  input  logic                 rst,
  bank_switch_if.slave         bus,
  output logic [7:0]           drop_cnt
);

  localparam int IDX_W = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

  logic                 ing_vld_q, ing_vld_d;
  pkt_t                 ing_pkt_q, ing_pkt_d;
  logic                 eg_vld_q, eg_vld_d;
  pkt_t                 eg_pkt_q, eg_pkt_d;
  logic [7:0]           drop_cnt_q, drop_cnt_d;

  logic [NUM_NODES-1:0] node_vld;
  logic                 ing_bad, ing_pop, ing_free;
  logic                 eg_free;
  logic                 cand_vld, cand_local, arb_en, arb_fire, local_fire;
  logic                 mesh_rdy, mesh_fire;
  logic [IDX_W-1:0]     cand_idx;
  logic [NUM_NODES-1:0] gnt;
  pkt_t                 cand_pkt;

  always_comb begin
    node_vld = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      node_vld[i] = ing_vld_q && (ing_pkt_q.addr.z == Z_W'(i));
    end
  end

  // A bad-z packet has no node_vld bit, so it leaves after exactly one cycle in the slot.
  assign ing_bad  = ing_pkt_q.addr.z >= Z_W'(NUM_NODES);
  assign ing_pop  = ing_vld_q && (ing_bad || (|(node_vld & bus.node_ready_out)));
  assign ing_free = !ing_vld_q || ing_pop;
  assign eg_free  = !eg_vld_q || bus.mesh_ready_out;

  assign cand_pkt = bus.node_in_pkt[cand_idx];

`ifdef BANK_LOCAL_BYPASS_EN
  assign cand_local = addr_in_bank(cand_pkt.addr, BANK_X, BANK_Y);
`else
  assign cand_local = 1'b0;
`endif

  // The candidate is never skipped: if its own destination slot is blocked, nobody is granted.
  assign arb_en     = cand_local ? ing_free : eg_free;
  assign arb_fire   = cand_vld && arb_en;
  assign local_fire = arb_fire && cand_local;
  assign mesh_rdy   = ing_free && !local_fire;
  assign mesh_fire  = bus.mesh_valid_in && mesh_rdy;

  rr_arbiter #(
    .N     (NUM_NODES),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.node_valid_in),
    .en       (arb_en),
    .cand_vld (cand_vld),
    .cand_idx (cand_idx),
    .gnt      (gnt)
  );

  always_comb begin
    ing_vld_d  = ing_vld_q;
    ing_pkt_d  = ing_pkt_q;
    eg_vld_d   = eg_vld_q;
    eg_pkt_d   = eg_pkt_q;
    drop_cnt_d = drop_cnt_q;

    if (ing_pop) ing_vld_d = 1'b0;
    if (local_fire) begin
      ing_vld_d = 1'b1;
      ing_pkt_d = cand_pkt;
    end else if (mesh_fire) begin
      ing_vld_d = 1'b1;
      ing_pkt_d = bus.mesh_in_pkt;
    end

    if (eg_vld_q && bus.mesh_ready_out) eg_vld_d = 1'b0;
    if (arb_fire && !cand_local) begin
      eg_vld_d = 1'b1;
      eg_pkt_d = cand_pkt;
    end

    if (ing_pop && ing_bad && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ing_vld_q  <= 1'b0;
      ing_pkt_q  <= '0;
      eg_vld_q   <= 1'b0;
      eg_pkt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      ing_vld_q  <= ing_vld_d;
      ing_pkt_q  <= ing_pkt_d;
      eg_vld_q   <= eg_vld_d;
      eg_pkt_q   <= eg_pkt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.mesh_ready_in  = mesh_rdy;
  assign bus.node_valid_out = node_vld;
  assign bus.node_out_pkt   = ing_pkt_q;
  assign bus.node_ready_in  = gnt;
  assign bus.mesh_valid_out = eg_vld_q;
  assign bus.mesh_out_pkt   = eg_pkt_q;
  assign drop_cnt           = drop_cnt_q;

endmodule

// File: tb/tb_bank_switch.sv
// Directed bench for bank_switch: ingress routing/hold, RR egress, stall, drops, local traffic, reset.
module tb_bank_switch;
  import bank_switch_pkg::*;

  localparam int NN = 4;
  localparam int BX = 1;
  localparam int BY = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] drop_cnt;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  bank_switch_if #(.NUM_NODES(NN)) bus ();

  bank_switch #(
    .BANK_X    (BX),
    .BANK_Y    (BY),
    .NUM_NODES (NN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic pkt_t mkp(input ctrl_e c, input int x, input int y, input int z, input int d);
    pkt_t p;
    p.ctrl   = c;
    p.addr.x = COORD_W'(x);
    p.addr.y = COORD_W'(y);
    p.addr.z = Z_W'(z);
    p.data   = DATA_W'(d);
    return p;
  endfunction

  pkt_t       pa, pb, pc, pd, pbad, p1b, pl, pm;
  pkt_t       p [NN];
  int         seq [3] = '{0, 1, 3};
  logic [3:0] oh;
  logic       any_nvo, all_rdy;

  initial begin
    bus.mesh_valid_in  = 1'b0;
    bus.mesh_in_pkt    = '0;
    bus.node_ready_out = '0;
    bus.node_valid_in  = '0;
    bus.node_in_pkt    = '0;
    bus.mesh_ready_out = 1'b0;
    for (int i = 0; i < NN; i++) p[i] = mkp(CTRL_SUM, 0, 0, 0, 'hA000 + i);

    // Reset state
    #2;
    check_val("rst_nvo", 64'(bus.node_valid_out), 64'h0);
    check_val("rst_nri", 64'(bus.node_ready_in), 64'h0);
    check_val("rst_mvo", 64'(bus.mesh_valid_out), 64'h0);
    check_val("rst_drop", 64'(drop_cnt), 64'h0);
    check_val("rst_mopkt", 64'(bus.mesh_out_pkt), 64'h0);
    check_val("rst_nopkt", 64'(bus.node_out_pkt), 64'h0);
    @(posedge clk); #1 rst = 1'b0; #1;
    check_val("rst_mri", 64'(bus.mesh_ready_in), 64'h1);

    // Ingress z=2, node ready
    pa = mkp(CTRL_CHILDREN, 0, 0, 2, 'h1111);
    bus.mesh_in_pkt = pa; bus.mesh_valid_in = 1'b1; bus.node_ready_out = 4'b0100; #1;
    check_val("ing_acc", 64'(bus.mesh_ready_in), 64'h1);
    tick; bus.mesh_valid_in = 1'b0; #1;
    check_val("ing_nvo", 64'(bus.node_valid_out), 64'h4);
    check_val("ing_pkt", 64'(bus.node_out_pkt), 64'(pa));
    tick;
    check_val("ing_done", 64'(bus.node_valid_out), 64'h0);

    // Ingress hold while node 2 not ready
    pb = mkp(CTRL_PARENTS, 3, 1, 2, 'h2222);
    bus.node_ready_out = 4'b0000; bus.mesh_in_pkt = pb; bus.mesh_valid_in = 1'b1;
    tick; bus.mesh_valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val("hold_nvo", 64'(bus.node_valid_out), 64'h4);
      check_val("hold_mri", 64'(bus.mesh_ready_in), 64'h0);
      check_val("hold_pkt", 64'(bus.node_out_pkt), 64'(pb));
      tick;
    end
    bus.node_ready_out = 4'b0100; #1;
    check_val("hold_rel_mri", 64'(bus.mesh_ready_in), 64'h1);
    tick;
    check_val("hold_done", 64'(bus.node_valid_out), 64'h0);

    // Back-to-back ingress, no bubble
    pc = mkp(CTRL_START, 0, 0, 0, 'h3333);
    pd = mkp(CTRL_SUM, 0, 0, 3, 'h4444);
    bus.node_ready_out = 4'hF; bus.mesh_in_pkt = pc; bus.mesh_valid_in = 1'b1;
    tick; bus.mesh_in_pkt = pd; #1;
    check_val("b2b_nvo0", 64'(bus.node_valid_out), 64'h1);
    check_val("b2b_pkt0", 64'(bus.node_out_pkt), 64'(pc));
    check_val("b2b_mri", 64'(bus.mesh_ready_in), 64'h1);
    tick; bus.mesh_valid_in = 1'b0; #1;
    check_val("b2b_nvo3", 64'(bus.node_valid_out), 64'h8);
    check_val("b2b_pkt3", 64'(bus.node_out_pkt), 64'(pd));
    tick;
    check_val("b2b_done", 64'(bus.node_valid_out), 64'h0);

    // Round-robin egress over nodes 0,1,3
    for (int i = 0; i < NN; i++) bus.node_in_pkt[i] = p[i];
    bus.node_valid_in = 4'b1011; bus.mesh_ready_out = 1'b1; #1;
    for (int i = 0; i < 6; i++) begin
      oh = 4'(1) << seq[i % 3];
      check_val("rr_gnt", 64'(bus.node_ready_in), 64'(oh));
      tick;
      check_val("rr_mvo", 64'(bus.mesh_valid_out), 64'h1);
      check_val("rr_pkt", 64'(bus.mesh_out_pkt), 64'(p[seq[i % 3]]));
    end
    bus.node_valid_in = 4'b0000;
    tick;
    check_val("rr_drain", 64'(bus.mesh_valid_out), 64'h0);

    // Egress stall: packet stable, no further grants
    bus.mesh_ready_out = 1'b0; bus.node_valid_in = 4'b0010; #1;
    check_val("stall_gnt0", 64'(bus.node_ready_in), 64'h2);
    tick;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_val("stall_mvo", 64'(bus.mesh_valid_out), 64'h1);
      check_val("stall_pkt", 64'(bus.mesh_out_pkt), 64'(p[1]));
      check_val("stall_nri", 64'(bus.node_ready_in), 64'h0);
      tick;
    end
    p1b = mkp(CTRL_SUM, 0, 0, 1, 'hB001);
    bus.node_in_pkt[1] = p1b; bus.mesh_ready_out = 1'b1; #1;
    check_val("stall_regnt", 64'(bus.node_ready_in), 64'h2);
    tick;
    check_val("stall_mvo2", 64'(bus.mesh_valid_out), 64'h1);
    check_val("stall_pkt2", 64'(bus.mesh_out_pkt), 64'(p1b));
    bus.node_valid_in = 4'b0000;
    tick;
    check_val("stall_drain", 64'(bus.mesh_valid_out), 64'h0);

    // Local-addressed egress packet (pointer now at 2, so node 0 is the candidate)
    pl = mkp(CTRL_SUM, BX, BY, 1, 'h5555);
    pm = mkp(CTRL_CHILDREN, 0, 0, 1, 'h6666);
    bus.node_in_pkt[0] = pl; bus.node_ready_out = 4'hF;
`ifdef BANK_LOCAL_BYPASS_EN
    bus.node_valid_in = 4'b0001; bus.mesh_in_pkt = pm; bus.mesh_valid_in = 1'b1; #1;
    check_val("byp_gnt", 64'(bus.node_ready_in), 64'h1);
    check_val("byp_mri", 64'(bus.mesh_ready_in), 64'h0);
    tick; bus.node_valid_in = 4'b0000; #1;
    check_val("byp_nvo_l", 64'(bus.node_valid_out), 64'h2);
    check_val("byp_pkt_l", 64'(bus.node_out_pkt), 64'(pl));
    check_val("byp_mvo_l", 64'(bus.mesh_valid_out), 64'h0);
    tick; bus.mesh_valid_in = 1'b0; #1;
    check_val("byp_nvo_m", 64'(bus.node_valid_out), 64'h2);
    check_val("byp_pkt_m", 64'(bus.node_out_pkt), 64'(pm));
    check_val("byp_mvo_m", 64'(bus.mesh_valid_out), 64'h0);
    tick;
    check_val("byp_done", 64'(bus.node_valid_out), 64'h0);
`else
    bus.node_valid_in = 4'b0001; #1;
    check_val("loc_gnt", 64'(bus.node_ready_in), 64'h1);
    check_val("loc_mri", 64'(bus.mesh_ready_in), 64'h1);
    tick; bus.node_valid_in = 4'b0000; #1;
    check_val("loc_mvo", 64'(bus.mesh_valid_out), 64'h1);
    check_val("loc_pkt", 64'(bus.mesh_out_pkt), 64'(pl));
    check_val("loc_nvo", 64'(bus.node_valid_out), 64'h0);
    tick;
    check_val("loc_drain", 64'(bus.mesh_valid_out), 64'h0);
`endif

    // Bad z: dropped, counter saturates
    pbad = mkp(CTRL_START, 0, 0, NN, 'h7777);
    bus.mesh_in_pkt = pbad; bus.mesh_valid_in = 1'b1;
    any_nvo = 1'b0; all_rdy = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      #1;
      any_nvo = any_nvo | (|bus.node_valid_out);
      all_rdy = all_rdy & bus.mesh_ready_in;
      tick;
      if (n == 10) check_val("drop_cnt10", 64'(drop_cnt), 64'd9);
    end
    bus.mesh_valid_in = 1'b0;
    tick;
    tick;
    check_val("drop_sat", 64'(drop_cnt), 64'd255);
    check_val("drop_nvo", 64'(any_nvo), 64'h0);
    check_val("drop_rdy", 64'(all_rdy), 64'h1);

    // Reset with both slots occupied
    bus.node_ready_out = 4'b0000; bus.mesh_ready_out = 1'b0;
    bus.mesh_in_pkt = pa; bus.mesh_valid_in = 1'b1;
    bus.node_in_pkt[3] = p[3]; bus.node_valid_in = 4'b1000;
    tick;
    bus.mesh_valid_in = 1'b0; bus.node_valid_in = 4'b0000; #1;
    check_val("mid_nvo_pre", 64'(bus.node_valid_out), 64'h4);
    check_val("mid_mvo_pre", 64'(bus.mesh_valid_out), 64'h1);
    rst = 1'b1; #1;
    check_val("mid_nvo", 64'(bus.node_valid_out), 64'h0);
    check_val("mid_mvo", 64'(bus.mesh_valid_out), 64'h0);
    check_val("mid_mopkt", 64'(bus.mesh_out_pkt), 64'h0);
    check_val("mid_drop", 64'(drop_cnt), 64'h0);
    @(posedge clk); #1 rst = 1'b0; #1;
    check_val("mid_mri", 64'(bus.mesh_ready_in), 64'h1);
    tick;
    check_val("mid_nvo_post", 64'(bus.node_valid_out), 64'h0);
    check_val("mid_mvo_post", 64'(bus.mesh_valid_out), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
